// File: rtl/seq_divider_32bit.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero completes immediately with an all-ones quotient and the dividend as remainder.
module seq_divider_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [W-1:0]    part, part_nxt;
    logic [W-1:0]    dq, dq_nxt;
    logic [W-1:0]    dsr, dsr_nxt;
    logic            busy_nxt, done_nxt, dbz_nxt;
    logic [W-1:0]    quotient_nxt, remainder_nxt;

    logic [W:0]      shifted;
    logic [W+1:0]    sum;
    logic            qbit;
    logic [W-1:0]    part_step;

    // State, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            part        <= '0;
            dq          <= '0;
            dsr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            part        <= part_nxt;
            dq          <= dq_nxt;
            dsr         <= dsr_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
        end
    end

    // One restoring step: 33-bit R' minus divisor via inverted add with carry-in.
    // No-borrow shows as sum[33:32] == 2'b10 because R' < 2*divisor always holds.
    always_comb begin
        shifted   = {part, dq[W-1]};
        sum       = {1'b0, shifted} + {1'b0, ~{1'b0, dsr}} + (W+2)'(1);
        qbit      = sum[W+1] & ~sum[W];
        part_step = qbit ? sum[W-1:0] : shifted[W-1:0];
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        part_nxt      = part;
        dq_nxt        = dq;
        dsr_nxt       = dsr;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        dbz_nxt       = div_by_zero;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;

        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    dbz_nxt = 1'b0;
                    if (divisor == '0) begin
                        state_nxt     = S_DONE;
                        done_nxt      = 1'b1;
                        dbz_nxt       = 1'b1;
                        quotient_nxt  = '1;
                        remainder_nxt = dividend;
                    end else begin
                        state_nxt = S_RUN;
                        busy_nxt  = 1'b1;
                        dq_nxt    = dividend;
                        dsr_nxt   = divisor;
                        part_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_RUN: begin
                part_nxt = part_step;
                dq_nxt   = {dq[W-2:0], qbit};
                cnt_nxt  = cnt + CW'(1);
                if (cnt == CW'(W-1)) begin
                    state_nxt     = S_DONE;
                    done_nxt      = 1'b1;
                    quotient_nxt  = {dq[W-2:0], qbit};
                    remainder_nxt = part_step;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Bench for seq_divider_32bit: cycle-level arithmetic model checked every cycle,
// plus directed divisions with hand-computed quotient, remainder and latency.
module tb_seq_divider_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    seq_divider_32bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: a division is "cycles left" plus a precomputed answer from / and %.
    int          m_left = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0; m_dbz = 0; m_q = '0; m_r = '0;
        end else if (m_left > 0) begin
            m_left--;
            m_busy = (m_left > 0);
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_q = m_pq;
                m_r = m_pr;
            end
        end else begin
            m_busy = 0;
            m_done = 0;
            if (start) begin
                m_dbz = 0;
                if (divisor == 0) begin
                    m_done = 1; m_dbz = 1; m_q = 32'hFFFF_FFFF; m_r = dividend;
                end else begin
                    m_pq = dividend / divisor;
                    m_pr = dividend % divisor;
                    m_left = 32;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_dbz",  {31'b0, div_by_zero}, {31'b0, m_dbz});
            chk("cyc_quot", quotient, m_q);
            chk("cyc_rem",  remainder, m_r);
        end
    end

    // Caller sits at a negedge; start is raised immediately and dropped one cycle later.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // k counts edges after the start edge; returns at the negedge of the done cycle.
    task automatic wait_done(input int k0, output int k, output int bc);
        k = k0; bc = 0;
        while (!done && k < 40) begin
            if (busy) bc++;
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                           input int ek, input int ebc);
        int k, bc;
        drive_start(a, b);
        wait_done(0, k, bc);
        chk({name, "_lat"},  32'(k), 32'(ek));
        chk({name, "_busy"}, 32'(bc), 32'(ebc));
        chk({name, "_q"},    quotient, eq);
        chk({name, "_r"},    remainder, er);
        chk({name, "_dbz"},  {31'b0, div_by_zero}, {31'b0, edbz});
    endtask

    initial begin
        int k, bc, dn;
        rst_n = 1'b0; start = 1'b1; dividend = 32'd9; divisor = 32'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32);
        @(negedge clk);
        run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 32);
        @(negedge clk);
        run_div("d8_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32, 32);
        @(negedge clk);
        run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0);
        @(negedge clk);
        run_div("dbig", 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 32, 32);
        repeat (3) @(negedge clk);
        chk("hold_q", quotient, 32'd123456);
        run_div("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32, 32);
        @(negedge clk);

        // start during RUN must be ignored
        drive_start(32'd3, 32'd10);
        repeat (9) @(negedge clk);
        drive_start(32'd50, 32'd5);
        wait_done(10, k, bc);
        chk("ign_lat", 32'(k), 32'd32);
        chk("ign_q", quotient, 32'd0);
        chk("ign_r", remainder, 32'd3);
        @(negedge clk);

        // reset mid-RUN abandons the division
        drive_start(32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_q", quotient, 32'd0);
        chk("mrst_r", remainder, 32'd0);
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("mrst_nodone", 32'(dn), 32'd0);
        run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, 32);
        @(negedge clk);

        // back-to-back: second start issued during the first done cycle
        run_div("b2b_a", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 32, 32);
        run_div("b2b_b", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 32, 32);
        @(negedge clk);
        chk("b2b_drop", {31'b0, done}, 32'd0);

        // zero divisor followed by a normal one clears div_by_zero
        run_div("dz2", 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, 1'b1, 0, 0);
        run_div("dz_clr", 32'd77, 32'd8, 32'd9, 32'd5, 1'b0, 32, 32);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider_32bit.md
SEQ_DIVIDER_32BIT -- requirements
Module: seq_divider_32bit

Interface
REQ-001 Parameters: none; all datapath widths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 start  input  1  request to begin a division; sampled on rising edge.
REQ-005 dividend  input  32  unsigned dividend; captured on accepted start.
REQ-006 divisor  input  32  unsigned divisor; captured on accepted start.
REQ-007 busy  output  1  high while an iteration sequence is in progress.
REQ-008 done  output  1  single-cycle pulse; quotient/remainder valid in that cycle.
REQ-009 quotient  output  32  unsigned quotient.
REQ-010 remainder  output  32  unsigned remainder.
REQ-011 div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; encoding free.
REQ-013 start SHALL be accepted only in IDLE or DONE; in RUN it SHALL be ignored, with no effect on state or captured operands.
REQ-014 On accepted start with divisor != 0: capture operands, clear 33-bit partial remainder R and iteration counter, go to RUN; busy=1 from the next cycle.
REQ-015 Each RUN cycle SHALL do one restoring step: R' = {R[31:0], next dividend MSB}; D = R' - {1'b0, divisor} as a 33-bit two's-complement subtract (invert divisor, carry-in 1); carry-out 1 (no borrow) -> R=D and quotient bit=1; carry-out 0 -> R=R' and quotient bit=0.
REQ-016 Quotient bits SHALL be produced MSB-first; exactly 32 RUN cycles per division, counted by a 6-bit counter.
REQ-017 After the 32nd RUN edge, state SHALL be DONE: done=1, busy=0, quotient/remainder final for one cycle; next edge -> IDLE unless start is accepted.
REQ-018 Latency: start accepted at edge N -> done high in the cycle after edge N+32.
REQ-019 On accepted start with divisor == 0: go directly to DONE; done=1 and div_by_zero=1 in the cycle after edge N; quotient=0xFFFFFFFF; remainder=dividend; no RUN cycles.
REQ-020 div_by_zero SHALL be 0 for every nonzero-divisor result and SHALL clear on the next accepted start.
REQ-021 quotient and remainder SHALL hold their last result through IDLE until the next result is written; intermediate values SHALL NOT be driven on these ports during RUN.
REQ-022 start in DONE SHALL be accepted same edge (back-to-back); done SHALL drop the next cycle.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for all nonzero divisors.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE with busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0, regardless of state or start.
REQ-025 Reset mid-RUN SHALL abandon the division; no done pulse SHALL follow for it.
REQ-026 start coinciding with rst_n=0 SHALL be ignored.

Verification
REQ-027 100 / 7, start at edge N -> busy cycles N+1..N+32, done after edge N+32, quotient=14, remainder=2, div_by_zero=0.
REQ-028 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000.
REQ-029 5 / 0 -> done and div_by_zero high in the cycle after the start edge, quotient=0xFFFFFFFF, remainder=5, busy never high.
REQ-030 3 / 10 started; start with 50 / 5 pulsed at RUN cycle 10 -> ignored; result quotient=0, remainder=3 at the normal latency.
REQ-031 rst_n low at RUN cycle 12 -> next cycle all outputs 0, state IDLE, no done; a new 9 / 3 start then yields quotient=3, remainder=0.
REQ-032 Back-to-back: 20 / 6 then start with 7 / 7 asserted during its done cycle -> first result 3/2, second result 1/0 exactly 33 cycles later.
